// File: rtl/vram_line_fetcher_if.sv
// rtl/vram_line_fetcher_if.sv - VRAM read port and FWFT output stream of the line fetcher
interface vram_line_fetcher_if;
    logic [14:0] bus_addr;
    logic        bus_strobe;
    logic        bus_ack;
    logic [31:0] bus_rddata;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    modport master (
        output bus_addr,
        output bus_strobe,
        input  bus_ack,
        input  bus_rddata,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  bus_addr,
        input  bus_strobe,
        output bus_ack,
        output bus_rddata,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/vram_line_fetcher.sv
// rtl/vram_line_fetcher.sv - fetches a run of VRAM words into an FWFT FIFO
module vram_line_fetcher #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [14:0]              start_addr,
    input  logic [CNT_W-1:0]         word_count,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    vram_line_fetcher_if.master      port
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [14:0]      base;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] acked_q;
    logic             done_q;

    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fifo_count;

    logic             ack_eff;
    logic             push;
    logic             pop;
    logic             launch;
    logic             last;
    logic [CNT_W:0]   k;
    logic [PTR_W+1:0] occupancy;

    // Acks only count while fetching, so a stray ack in IDLE never moves the address.
    always_comb begin
        ack_eff   = port.bus_ack && (state == FETCH);
        k         = {1'b0, acked_q} + (CNT_W+1)'(ack_eff);
        occupancy = {1'b0, fifo_count} + (PTR_W+2)'(ack_eff);
        push      = ack_eff && !abort;
        pop       = port.out_valid && port.out_ready && !abort;
        last      = push && (k == {1'b0, len});
    end

    // The occupancy test reserves a slot for the request in flight and ignores a same-cycle pop.
    always_comb begin
        port.bus_addr   = base + 15'(k);
        port.bus_strobe = (state == FETCH) && !abort && (k < {1'b0, len})
                          && (occupancy < (PTR_W+2)'(FIFO_DEPTH));
        port.out_valid  = (fifo_count != '0);
        port.out_data   = port.out_valid ? mem[rd_ptr] : 32'h0;
        busy            = (state == FETCH);
        done            = done_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (word_count != '0)) begin
                        state_nxt = FETCH;
                        launch    = 1'b1;
                    end
                end
                FETCH: begin
                    if (last) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base    <= '0;
            len     <= '0;
            acked_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last;
            if (launch) begin
                base    <= start_addr;
                len     <= word_count;
                acked_q <= '0;
            end else if (push) begin
                acked_q <= acked_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (abort) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= port.bus_rddata;
        end
    end
endmodule
